// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared FSM state encoding and PC step constant for fetch_pc_unit.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
// Module   : pc_reg
// Purpose  : Program counter register with load and wrapping +PC_STEP advance.
// Revision : 1.0 - initial release
// ============================================================================
module pc_reg
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_target,
  input  logic              i_adv,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc_plus4
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_plus4;

  // Truncation to ADDR_W gives the modulo-2^ADDR_W wrap for free.
  assign w_pc_plus4 = r_pc + ADDR_W'(PC_STEP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_target;
    end else if (i_adv) begin
      r_pc <= w_pc_plus4;
    end
  end

  assign o_pc       = r_pc;
  assign o_pc_plus4 = w_pc_plus4;

endmodule : pc_reg
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_unit
// Purpose  : Fetch PC sequencer (BOOT/RUN/HALT) with stall, redirect, halt and
//            decode handshake. Optional target alignment check enabled by the
//            macro FETCH_PC_ALIGN_CHK_EN (adds sticky misalign_o).
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                IDX_W    = 6,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic              halt_i,
  input  logic              ready_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic [ADDR_W-1:0] pc_plus4_o,
  output logic              valid_o,
  output logic              flush_o
`ifdef FETCH_PC_ALIGN_CHK_EN
 ,output logic              misalign_o
`endif
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic              r_flush;
  logic              w_flush_nxt;
  logic              w_load;
  logic              w_adv;
  logic              w_aligned;
  logic [ADDR_W-1:0] w_target;
  logic              w_valid;

`ifdef FETCH_PC_ALIGN_CHK_EN
  logic r_misalign;
  logic w_mis_set;
  logic w_mis_clr;
  assign w_aligned = (target_i[1:0] == 2'b00);
  assign w_target  = target_i;
`else
  assign w_aligned = 1'b1;
  assign w_target  = target_i & ~ADDR_W'(2'b11);
`endif

  // The cycle after an accepted redirect is the bubble: flush pulses, no fetch.
  assign w_valid = (r_state == ST_RUN) && !r_flush;

  always_comb begin
    w_state_nxt = r_state;
    w_flush_nxt = 1'b0;
    w_load      = 1'b0;
    w_adv       = 1'b0;
`ifdef FETCH_PC_ALIGN_CHK_EN
    w_mis_set   = 1'b0;
    w_mis_clr   = 1'b0;
`endif
    unique case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN, ST_HALT: begin
        if (redirect_i) begin
          if (w_aligned) begin
            w_load      = 1'b1;
            w_flush_nxt = 1'b1;
            w_state_nxt = ST_RUN;
`ifdef FETCH_PC_ALIGN_CHK_EN
            w_mis_clr   = 1'b1;
`endif
          end else begin
            w_state_nxt = ST_HALT;
`ifdef FETCH_PC_ALIGN_CHK_EN
            w_mis_set   = 1'b1;
`endif
          end
        end else if (r_state == ST_RUN) begin
          if (halt_i) begin
            w_state_nxt = ST_HALT;
          end else if (!stall_i && w_valid && ready_i) begin
            w_adv = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_BOOT;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_flush <= w_flush_nxt;
    end
  end

`ifdef FETCH_PC_ALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_misalign <= 1'b0;
    end else if (w_mis_set) begin
      r_misalign <= 1'b1;
    end else if (w_mis_clr) begin
      r_misalign <= 1'b0;
    end
  end
  assign misalign_o = r_misalign;
`endif

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_target   (w_target),
    .i_adv      (w_adv),
    .o_pc       (pc_o),
    .o_pc_plus4 (pc_plus4_o)
  );

  assign idx_o   = pc_o[IDX_W+1:2];
  assign valid_o = w_valid;
  assign flush_o = r_flush;

endmodule : fetch_pc_unit
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pc_unit
// Purpose  : Directed self-checking bench: 32-bit instance for sequencing,
//            8-bit instance for PC wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect, halt, ready;
  logic [31:0] target;
  logic [31:0] pc, pc4;
  logic [5:0]  idx;
  logic        valid, flush;

  logic        rst_b;
  logic [7:0]  pc_b, pc4_b;
  logic [5:0]  idx_b;
  logic        valid_b, flush_b;

  int checks   = 0;
  int failures = 0;

`ifdef FETCH_PC_ALIGN_CHK_EN
  logic misalign, misalign_b;
`endif

  always #5 clk = ~clk;

  fetch_pc_unit #(.ADDR_W(32), .IDX_W(6), .RESET_PC(32'h100)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall),
    .redirect_i (redirect),
    .target_i   (target),
    .halt_i     (halt),
    .ready_i    (ready),
    .pc_o       (pc),
    .idx_o      (idx),
    .pc_plus4_o (pc4),
    .valid_o    (valid),
    .flush_o    (flush)
`ifdef FETCH_PC_ALIGN_CHK_EN
   ,.misalign_o (misalign)
`endif
  );

  fetch_pc_unit #(.ADDR_W(8), .IDX_W(6), .RESET_PC(8'hF0)) u_dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .stall_i    (1'b0),
    .redirect_i (1'b0),
    .target_i   (8'h00),
    .halt_i     (1'b0),
    .ready_i    (1'b1),
    .pc_o       (pc_b),
    .idx_o      (idx_b),
    .pc_plus4_o (pc4_b),
    .valid_o    (valid_b),
    .flush_o    (flush_b)
`ifdef FETCH_PC_ALIGN_CHK_EN
   ,.misalign_o (misalign_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land 1 ns after it for sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; rst_b = 1'b0;
    stall = 1'b0; redirect = 1'b0; halt = 1'b0; ready = 1'b1; target = '0;

    #12;
    chk("rst_pc",    pc,    32'h100);
    chk("rst_idx",   idx,   32'h0);
    chk("rst_pc4",   pc4,   32'h104);
    chk("rst_valid", valid, 32'h0);
    chk("rst_flush", flush, 32'h0);
`ifdef FETCH_PC_ALIGN_CHK_EN
    chk("rst_mis",   misalign, 32'h0);
`endif

    step();
    rst = 1'b1;
    chk("boot_valid", valid, 32'h0);
    step();
    chk("run_pc",    pc,    32'h100);
    chk("run_idx",   idx,   32'h0);
    chk("run_valid", valid, 32'h1);
    step();
    chk("adv_pc",    pc,    32'h104);

    // Backpressure at 0x8
    redirect = 1'b1; target = 32'h8;
    step();
    chk("rd8_pc",    pc,    32'h8);
    chk("rd8_flush", flush, 32'h1);
    chk("rd8_valid", valid, 32'h0);
    redirect = 1'b0;
    step();
    chk("bub8_pc",    pc,    32'h8);
    chk("bub8_valid", valid, 32'h1);
    chk("bub8_flush", flush, 32'h0);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_pc",    pc,    32'h8);
      chk("bp_valid", valid, 32'h1);
    end
    ready = 1'b1;
    step();
    chk("bp_rel_pc", pc, 32'hC);

    // Redirect beats stall
    redirect = 1'b1; stall = 1'b1; target = 32'h40;
    step();
    chk("rs_pc",    pc,    32'h40);
    chk("rs_flush", flush, 32'h1);
    chk("rs_valid", valid, 32'h0);
    redirect = 1'b0; stall = 1'b0;
    step();
    chk("rs_pc2",    pc,    32'h40);
    chk("rs_valid2", valid, 32'h1);
    chk("rs_flush2", flush, 32'h0);
    step();
    chk("rs_adv", pc, 32'h44);
    stall = 1'b1;
    step();
    chk("stall_pc",    pc,    32'h44);
    chk("stall_valid", valid, 32'h1);
    stall = 1'b0;

    // Halt and resume
    redirect = 1'b1; target = 32'h20;
    step();
    redirect = 1'b0;
    step();
    chk("h_pc0", pc, 32'h20);
    halt = 1'b1;
    step();
    halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("halt_valid", valid, 32'h0);
      chk("halt_pc",    pc,    32'h20);
      step();
    end
    redirect = 1'b1; halt = 1'b1; target = 32'h80;
    step();
    chk("res_pc",    pc,    32'h80);
    chk("res_flush", flush, 32'h1);
    chk("res_valid", valid, 32'h0);
    redirect = 1'b0; halt = 1'b0;
    step();
    chk("res_valid2", valid, 32'h1);
    chk("res_pc2",    pc,    32'h80);
    chk("res_idx",    idx,   32'h20);
    chk("res_pc4",    pc4,   32'h84);

`ifdef FETCH_PC_ALIGN_CHK_EN
    redirect = 1'b1; target = 32'h42;
    step();
    chk("mis_flag",  misalign, 32'h1);
    chk("mis_pc",    pc,       32'h80);
    chk("mis_valid", valid,    32'h0);
    chk("mis_flush", flush,    32'h0);
    target = 32'h44;
    step();
    chk("al_flag",  misalign, 32'h0);
    chk("al_pc",    pc,       32'h44);
    chk("al_flush", flush,    32'h1);
    redirect = 1'b0;
    step();
    chk("al_valid", valid, 32'h1);
`else
    redirect = 1'b1; target = 32'h93;
    step();
    chk("lowbits_pc",    pc,    32'h90);
    chk("lowbits_flush", flush, 32'h1);
    redirect = 1'b0;
    step();
    chk("lowbits_valid", valid, 32'h1);
`endif

    // Asynchronous reset during a bubble
    redirect = 1'b1; target = 32'h50;
    step();
    chk("pre_rst_flush", flush, 32'h1);
    redirect = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_flush", flush, 32'h0);
    chk("arst_valid", valid, 32'h0);
    chk("arst_pc",    pc,    32'h100);

    // 8-bit wrap-around
    chk("b_rst_pc", pc_b, 32'hF0);
    step();
    rst_b = 1'b1;
    step();
    chk("b_pc_f0", pc_b, 32'hF0);
    step();
    step();
    step();
    chk("b_pc_fc",  pc_b,  32'hFC);
    chk("b_idx_fc", idx_b, 32'h3F);
    chk("b_pc4_fc", pc4_b, 32'h00);
    step();
    chk("b_wrap_pc",    pc_b,    32'h00);
    chk("b_wrap_idx",   idx_b,   32'h00);
    chk("b_wrap_valid", valid_b, 32'h1);
    chk("b_wrap_flush", flush_b, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fetch_pc_unit
`default_nettype wire

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: PC width in bits; legal range 8..32.
REQ-002 SHALL have parameter IDX_W, default 6: instruction-memory word index width; IDX_W+2 <= ADDR_W.
REQ-003 SHALL have parameter RESET_PC, default 0: PC value loaded at reset; low two bits are 0.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset; asserts immediately, releases synchronously to clk.
REQ-006 SHALL have port stall_i, input, 1 bit: a downstream hazard freezes the PC.
REQ-007 SHALL have port redirect_i, input, 1 bit: a taken branch or jump.
REQ-008 SHALL have port target_i, input, ADDR_W bits: the redirect destination.
REQ-009 SHALL have port halt_i, input, 1 bit: stop fetching.
REQ-010 SHALL have port ready_i, input, 1 bit: decode accepts the current fetch.
REQ-011 SHALL have port pc_o, output, ADDR_W bits: the registered current PC.
REQ-012 SHALL have port idx_o, output, IDX_W bits: pc_o[IDX_W+1:2].
REQ-013 SHALL have port pc_plus4_o, output, ADDR_W bits: pc_o+4, modulo 2^ADDR_W.
REQ-014 SHALL have port valid_o, output, 1 bit: pc_o/idx_o hold a fetch offered to decode.
REQ-015 SHALL have port flush_o, output, 1 bit: one-cycle pulse on an accepted redirect.

Function
REQ-016 SHALL implement an FSM with states BOOT, RUN and HALT.
- BOOT: valid_o=0; moves to RUN on the next edge.
- RUN: valid_o=1 except during a redirect bubble.
- HALT: valid_o=0 and the PC is frozen.
REQ-017 SHALL advance the PC (pc <= pc+4, wrapping at 2^ADDR_W) only when valid_o & ready_i & !stall_i & !redirect_i are all true in RUN.
REQ-018 SHALL hold pc_o, idx_o and valid_o stable while valid_o=1 and ready_i=0, or while stall_i=1.
REQ-019 SHALL, when redirect_i=1 in RUN or HALT, load pc <= target_i on the next edge, pulse flush_o=1 for that one cycle, and force valid_o=0 for that cycle (one bubble).
REQ-020 SHALL, when redirect_i=1 in HALT, move the FSM to RUN.
REQ-021 SHALL give the following priority when several inputs are active in the same cycle: redirect_i > halt_i > stall_i > advance.
REQ-022 SHALL, on halt_i=1 without redirect_i in RUN, enter HALT on the next edge with the PC unchanged; halt_i has no further effect once in HALT.
REQ-023 SHALL ignore redirect_i, halt_i and stall_i in BOOT.
REQ-024 SHALL derive idx_o and pc_plus4_o combinationally from the registered PC only (no input-to-output paths).
REQ-025 SHALL, if rst asserts mid-operation, abandon any pending bubble or halt at once.

Reset
REQ-026 SHALL, while rst=0, hold pc_o=RESET_PC, idx_o=RESET_PC[IDX_W+1:2], pc_plus4_o=RESET_PC+4, valid_o=0, flush_o=0, FSM=BOOT (and misalign_o=0 when the REQ-027 feature is compiled in).

Configuration
REQ-027 SHALL, when macro FETCH_PC_ALIGN_CHK_EN is defined, behave as follows:
- add output misalign_o, 1 bit;
- a redirect with target_i[1:0]!=0 does not load the PC;
- misalign_o is set and the FSM enters HALT on the next edge;
- misalign_o is sticky until reset or an aligned redirect, which clears it.
REQ-028 SHALL, without FETCH_PC_ALIGN_CHK_EN, have no misalign_o port and load target_i with bits [1:0] forced to 0.

Structure
REQ-029 SHALL take the FSM state enumeration (BOOT/RUN/HALT encodings) and the PC_STEP=4 constant from the shared package fetch_pkg.
REQ-030 SHALL keep the PC register, incrementer and wrap logic in one sub-module, pc_reg, with the FSM and handshake logic in fetch_pc_unit.

Verification
REQ-031 SHALL cover reset release with RESET_PC=0x100 and ready_i=1:
- cycle 0: BOOT, valid_o=0;
- cycle 1: pc_o=0x100, idx_o=0;
- cycle 2: pc_o=0x104.
REQ-032 SHALL cover backpressure: ready_i=0 for 3 cycles at pc_o=0x8 -> pc_o stays 0x8 and valid_o stays 1; first ready_i=1 cycle -> pc_o=0xC next edge.
REQ-033 SHALL cover redirect vs stall: redirect_i=1, stall_i=1, target_i=0x40 in the same cycle -> next cycle pc_o=0x40, flush_o=1, valid_o=0; then valid_o=1.
REQ-034 SHALL cover wrap-around with ADDR_W=8: pc_o=0xFC advanced -> pc_o=0x00; idx_o wraps to 0.
REQ-035 SHALL cover halt and resume: halt_i=1 at pc_o=0x20 -> HALT, valid_o=0 for 10 cycles; redirect_i=1, target_i=0x80 -> RUN, pc_o=0x80.
REQ-036 SHALL cover the alignment check with FETCH_PC_ALIGN_CHK_EN defined: redirect to 0x42 -> misalign_o=1, HALT, pc unchanged; redirect to 0x44 -> misalign_o=0, pc_o=0x44.
